// File: rtl/alu_operand_loader_pkg.sv
// Shared definitions for the ALU operand loader.
// State encodings and beat-count helpers.
package alu_operand_loader_pkg;

    localparam logic [1:0] S_OP   = 2'd0;
    localparam logic [1:0] S_A    = 2'd1;
    localparam logic [1:0] S_B    = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    function automatic int beats_f(input int n, input int bus_w);
        return n / bus_w;
    endfunction

    function automatic int cnt_w_f(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    function automatic bit legal_f(input int n, input int bus_w,
                                   input int op_w);
        return (bus_w > 0) && (n % bus_w == 0) && (op_w <= bus_w);
    endfunction

endpackage

// File: rtl/alu_operand_loader_beat_shift_reg.sv
// Slice-write register: one BUS_W beat written per load at index idx_i.
// next_o shows the register value with the pending beat merged in.
module beat_shift_reg #(
    parameter int N     = 8,
    parameter int BUS_W = 4,
    parameter int IDX_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [BUS_W-1:0] data_i,
    output logic [N-1:0]     q_o,
    output logic [N-1:0]     next_o
);

    logic [N-1:0] q_q;

    always_comb begin
        next_o = q_q;
        next_o[idx_i*BUS_W +: BUS_W] = data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (load_i) begin
            q_q <= next_o;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Host-bus operand loader: gathers opcode/A/B beat by beat and presents
// them to the ALU as one atomic, held set until acknowledged.
module alu_operand_loader
    import alu_operand_loader_pkg::*;
#(
    parameter int N     = 8,
    parameter int BUS_W = 4,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BUS_W-1:0] bus_data,
    input  logic             wr,
    input  logic             clr,
    output logic             ready,
    output logic [OP_W-1:0]  op,
    output logic [N-1:0]     a,
    output logic [N-1:0]     b,
    output logic             valid,
    input  logic             ack
);

    localparam int BEATS = beats_f(N, BUS_W);
    localparam int CNT_W = cnt_w_f(BEATS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    generate
        if (!legal_f(N, BUS_W, OP_W)) begin : g_illegal
            $error("alu_operand_loader: need N %% BUS_W == 0 and OP_W <= BUS_W");
        end
    endgenerate

    logic [1:0]      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OP_W-1:0] op_sh_q, op_sh_d;
    logic [OP_W-1:0] op_q;
    logic [N-1:0]    a_q, b_q;
    logic            valid_q, valid_d;
    logic            ready_q;

    logic [N-1:0] a_sh, a_next, b_sh, b_next;
    logic accept, take, last, ld_a, ld_b, commit;

    assign accept = wr & ready_q;
    assign take   = accept & ~clr;
    assign last   = (cnt_q == LAST);
    assign ld_a   = take & (state_q == S_A);
    assign ld_b   = take & (state_q == S_B);
    assign commit = ld_b & last;

    beat_shift_reg #(.N(N), .BUS_W(BUS_W), .IDX_W(CNT_W)) u_sh_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (ld_a),
        .idx_i  (cnt_q),
        .data_i (bus_data),
        .q_o    (a_sh),
        .next_o (a_next)
    );

    beat_shift_reg #(.N(N), .BUS_W(BUS_W), .IDX_W(CNT_W)) u_sh_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (ld_b),
        .idx_i  (cnt_q),
        .data_i (bus_data),
        .q_o    (b_sh),
        .next_o (b_next)
    );

    logic unused_bits;
    assign unused_bits = ^{a_next, b_sh, bus_data};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_sh_d = op_sh_q;
        valid_d = valid_q;
        if (clr) begin
            state_d = S_OP;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_OP: if (accept) begin
                    op_sh_d = bus_data[OP_W-1:0];
                    state_d = S_A;
                end
                S_A: if (accept) begin
                    if (last) begin
                        cnt_d   = '0;
                        state_d = S_B;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_B: if (accept) begin
                    if (last) begin
                        cnt_d   = '0;
                        state_d = S_HOLD;
                        valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_HOLD: if (ack) begin
                    state_d = S_OP;
                    valid_d = 1'b0;
                end
                default: state_d = S_OP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_OP;
            cnt_q   <= '0;
            op_sh_q <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_sh_q <= op_sh_d;
            valid_q <= valid_d;
            ready_q <= (state_d != S_HOLD);
            // Final B beat bypasses its shadow so the set lands in one edge
            if (commit) begin
                op_q <= op_sh_q;
                a_q  <= a_sh;
                b_q  <= b_next;
            end
        end
    end

    assign ready = ready_q;
    assign valid = valid_q;
    assign op    = op_q;
    assign a     = a_q;
    assign b     = b_q;

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Front-end stage of the CPLD ALU. Collects an opcode and two N-bit operands from a narrow host bus, one beat at a time, into shadow registers.
- Presents the completed opcode/A/B set atomically to the ALU logic array (generic gate modules such as the N-input NAND) and holds it stable until the downstream result stage acknowledges.
- Decouples slow host transfers from the combinational datapath, so the gates never see half-loaded operands.

Parameters:
- N, 8, operand width in bits; must be a multiple of BUS_W.
- BUS_W, 4, host data bus width in bits.
- OP_W, 4, opcode width; must satisfy OP_W <= BUS_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bus_data  input  BUS_W  host beat data.
- wr  input  1  host write strobe; a beat is accepted on a rising edge where wr=1 and ready=1.
- clr  input  1  synchronous abort; returns the loader to opcode phase.
- ready  output  1  loader can accept a beat.
- op  output  OP_W  opcode presented to the ALU.
- a  output  N  operand A presented to the ALU.
- b  output  N  operand B presented to the ALU.
- valid  output  1  op/a/b form a complete, stable set.
- ack  input  1  downstream has consumed the set; meaningful only while valid=1.

Behaviour:
- Reset (async, rst_n=0): state=S_OP, beat count=0, shadow registers=0, op=0, a=0, b=0, valid=0, ready=1.
- BEATS = N/BUS_W. Operands load least-significant beat first. Beat k occupies bits [k*BUS_W +: BUS_W].
- States:
  - S_OP: on accept, shadow_op <= bus_data[OP_W-1:0]; go to S_A.
  - S_A: on accept, fill the shadow_a slice, count++. On the last beat, count=0 and go to S_B.
  - S_B: on accept, fill the shadow_b slice, count++. On the last beat, count=0 and go to S_HOLD.
  - S_HOLD: waits for ack.
- Commit: on the same edge that accepts the final B beat, op/a/b load from the shadows (final beat taken directly from bus_data) and valid<=1. Outputs are visible one cycle after the final wr cycle.
- op/a/b change only at commit or reset. They never change during loading, and they hold their last values after ack.
- ready = 1 in S_OP/S_A/S_B and 0 in S_HOLD. ready is a registered state decode with no combinational path from wr.
- In S_HOLD, ack=1 on an edge gives valid<=0 and state=S_OP; ready is high the next cycle.
- ack while valid=0 is ignored. wr while ready=0 is ignored and no data is captured.
- clr=1 on an edge gives state=S_OP, count=0, valid<=0; shadows are left unchanged and op/a/b retain their values.
- clr takes priority over wr and ack in the same cycle; that cycle's beat is discarded.
- wr held high for several cycles gives one beat per cycle; back-to-back beats are legal.
- BEATS=1 is legal: S_A and S_B each last one beat.
- Partial loads never assert valid.
- rst_n asserted mid-load or in S_HOLD gives the immediate reset values above.

Decomposition:
- Shared package/header: state encodings S_OP, S_A, S_B, S_HOLD (2 bits) and the BEATS derivation. Include a parameter-legality check that fails elaboration if N%BUS_W!=0 or OP_W>BUS_W.
- Natural sub-module: beat_shift_reg (parameters N, BUS_W; a slice-write register with load-enable and index). Instantiate it twice, for A and B.

Test Plan:
All scenarios use defaults N=8, BUS_W=4, OP_W=4.
- Basic load: reset, then wr beats 0x3,0x5,0xA,0xC,0x3 -> after the 5th accept edge, valid=1, op=0x3, a=0xA5, b=0x3C, ready=0; op/a/b stay unchanged while ack=0 for 10 cycles.
- Ack/reload: ack=1 for one cycle -> valid=0 and ready=1 next cycle, outputs still 0xA5/0x3C. Then load 0x1,0xF,0x0,0x1,0x0 -> a=0x0F, b=0x01, op=0x1.
- Ignored strobes: wr pulses with bus_data=0xE while valid=1 and ready=0 -> no output change. A subsequent load after ack is captured correctly.
- Abort: accept 0x2,0x7 then clr=1 together with wr and bus_data=0x9 -> state S_OP, valid=0, no capture; outputs keep their prior values; a fresh 5-beat load succeeds.
- Async reset mid-load: rst_n=0 after 3 beats, between clock edges -> op/a/b=0, valid=0, ready=1 immediately; a full load afterwards works.
- Edge cases: ack with valid=0 is ignored; clr and ack together in S_HOLD -> valid=0, state S_OP. Repeat the basic load with BUS_W=8 -> 3 beats total.
